// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and widths for the multiplier sequencer.
package mult_seq_ctrl_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_seq_ctrl.sv
// Purpose: feeds operand pairs to a shift-add multiplier, returns products, accumulates, watchdogs.
// Latency: out_valid rises 10 cycles after input acceptance; one transaction per 12 cycles at best.
// Backpressure: product holds in HOLD until out_ready; in_ready stays low until then.
module mult_seq_ctrl
    import mult_seq_ctrl_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter int TIMEOUT = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_a,
    input  logic [7:0]        in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic [ACC_W-1:0]  acc,
    input  logic              acc_clr,
    output logic              err,
    input  logic              err_clr,
    output logic              mult_start,
    output logic [7:0]        mult_a,
    output logic [7:0]        mult_b,
    input  logic              mult_ready,
    input  logic [15:0]       mult_result
);

    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept, capture, timeout;
    logic [ACC_W-1:0] acc_base;

    assign in_ready   = (state == IDLE);
    assign mult_start = (state == START);
    assign acc_base   = acc_clr ? '0 : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START: state_nxt = WAIT;
            WAIT: begin
                // The multiplier was re-initialised at the START edge, so ready is genuine here.
                if (mult_ready) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_a    <= '0;
            mult_b    <= '0;
            wait_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (accept) begin
                mult_a <= in_a;
                mult_b <= in_b;
            end
            if (state == START)     wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
            if (capture) begin
                out_data  <= mult_result;
                out_valid <= 1'b1;
            end else if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Clear-then-add when acc_clr coincides with a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       acc <= '0;
        else if (capture) acc <= acc_base + ACC_W'(mult_result);
        else if (acc_clr) acc <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err <= 1'b0;
        else if (timeout) err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl with a behavioural 8-cycle multiplier and an ACC_W=16 twin in lockstep.
module tb_mult_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_a = '0, in_b = '0;
    logic        out_ready = 1'b0;
    logic        acc_clr = 1'b0, err_clr = 1'b0;
    logic        in_ready, out_valid, err, mult_start;
    logic [15:0] out_data;
    logic [23:0] acc;
    logic [7:0]  mult_a, mult_b;
    logic        mult_ready;
    logic [15:0] mult_result;

    logic        in_ready16, out_valid16, err16, mult_start16;
    logic [15:0] out_data16, acc16;
    logic [7:0]  mult_a16, mult_b16;

    // multiplier model
    logic        m_busy = 1'b0;
    logic [3:0]  m_cnt = '0;
    logic [15:0] m_res = '0;
    logic        stuck = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [15:0] q[$];

    always #5 clk = ~clk;

    assign mult_ready  = ~m_busy & ~stuck;
    assign mult_result = m_res;

    always @(posedge clk) begin
        if (mult_start) begin
            m_busy <= 1'b1;
            m_cnt  <= '0;
            m_res  <= 16'hFFFF;
        end else if (m_busy) begin
            m_cnt <= m_cnt + 4'd1;
            if (m_cnt == 4'd7) begin
                m_busy <= 1'b0;
                m_res  <= 16'(mult_a) * 16'(mult_b);
            end
        end
    end

    mult_seq_ctrl #(.ACC_W(24), .TIMEOUT(12)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .acc(acc), .acc_clr(acc_clr), .err(err), .err_clr(err_clr),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_ready(mult_ready), .mult_result(mult_result)
    );

    mult_seq_ctrl #(.ACC_W(16), .TIMEOUT(12)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid16), .out_ready(out_ready),
        .out_data(out_data16), .acc(acc16), .acc_clr(acc_clr), .err(err16), .err_clr(err_clr),
        .mult_start(mult_start16), .mult_a(mult_a16), .mult_b(mult_b16),
        .mult_ready(mult_ready), .mult_result(mult_result)
    );

    // Drives one operand pair; returns at the falling edge after the acceptance edge.
    task automatic do_accept(input logic [7:0] a, input logic [7:0] b, input bit push);
        int g = 0;
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            tests++; fails++;
            $display("FAIL accept_timeout in_ready=%0d required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (push) q.push_back(16'(a) * 16'(b));
    endtask

    // Counts falling edges until out_valid; also counts cycles where in_ready was high.
    task automatic wait_valid(output int n, output int rdy_hi);
        n = 0; rdy_hi = 0;
        while (!out_valid && n < 40) begin
            if (in_ready) rdy_hi++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_acc_clr();
        @(negedge clk); acc_clr = 1'b1;
        @(negedge clk); acc_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL rst_in_ready got %0d want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %0d want 0", out_valid); end
        tests++; if (out_data !== 16'd0) begin fails++; $display("FAIL rst_out_data got %0d want 0", out_data); end
        tests++; if (acc !== 24'd0)      begin fails++; $display("FAIL rst_acc got %0d want 0", acc); end
        tests++; if (err !== 1'b0)       begin fails++; $display("FAIL rst_err got %0d want 0", err); end
        tests++; if (mult_start !== 1'b0) begin fails++; $display("FAIL rst_mult_start got %0d want 0", mult_start); end
        tests++; if ({mult_a, mult_b} !== 16'd0) begin fails++; $display("FAIL rst_mult_ab got %0h want 0", {mult_a, mult_b}); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int n, r;
        logic [15:0] exp;
        out_ready = 1'b1;
        do_accept(8'd13, 8'd11, 1'b1);
        tests++; if (mult_start !== 1'b1) begin fails++; $display("FAIL single_start got %0d want 1", mult_start); end
        wait_valid(n, r);
        tests++; if (n != 10) begin fails++; $display("FAIL single_latency got %0d want 10", n); end
        exp = q.pop_front();
        tests++; if (out_data !== exp) begin fails++; $display("FAIL single_data got %0d want %0d", out_data, exp); end
        tests++; if (acc !== 24'd143) begin fails++; $display("FAIL single_acc got %0d want 143", acc); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL single_done got v=%0d r=%0d want v=0 r=1", out_valid, in_ready); end
        tests++; if (out_data !== 16'd143) begin fails++; $display("FAIL single_retain got %0d want 143", out_data); end
    endtask

    task automatic test_back_to_back();
        int n, r;
        logic [15:0] exp;
        pulse_acc_clr();
        tests++; if (acc !== 24'd0) begin fails++; $display("FAIL b2b_clr got %0d want 0", acc); end
        do_accept(8'd255, 8'd255, 1'b1);
        wait_valid(n, r);
        exp = q.pop_front();
        tests++; if (out_data !== exp) begin fails++; $display("FAIL b2b_data0 got %0d want %0d", out_data, exp); end
        tests++; if (r != 0 || in_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready0 got %0d high cycles want 0", r); end
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_rise got %0d want 1", in_ready); end
        do_accept(8'd2, 8'd3, 1'b1);
        wait_valid(n, r);
        exp = q.pop_front();
        tests++; if (out_data !== exp) begin fails++; $display("FAIL b2b_data1 got %0d want %0d", out_data, exp); end
        tests++; if (r != 0) begin fails++; $display("FAIL b2b_ready1 got %0d high cycles want 0", r); end
        tests++; if (acc !== 24'd65031) begin fails++; $display("FAIL b2b_acc got %0d want 65031", acc); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int n, r, bad;
        logic [15:0] exp;
        out_ready = 1'b0;
        do_accept(8'd20, 8'd30, 1'b1);
        wait_valid(n, r);
        tests++; if (n != 10) begin fails++; $display("FAIL bp_latency got %0d want 10", n); end
        in_valid = 1'b1; in_a = 8'd99; in_b = 8'd99;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_data !== 16'd600 || out_valid !== 1'b1 || in_ready !== 1'b0 || mult_start !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_release got r=%0d v=%0d want r=1 v=0", in_ready, out_valid); end
        exp = q.pop_front();
        tests++; if (out_data !== exp) begin fails++; $display("FAIL bp_data got %0d want %0d", out_data, exp); end
        tests++; if (mult_a !== 8'd20) begin fails++; $display("FAIL bp_ignore_a got %0d want 20", mult_a); end
    endtask

    task automatic test_wrap();
        int n, r;
        logic [15:0] exp;
        out_ready = 1'b1;
        pulse_acc_clr();
        for (int k = 0; k < 2; k++) begin
            do_accept(8'd255, 8'd255, 1'b1);
            wait_valid(n, r);
            exp = q.pop_front();
            tests++; if (out_data16 !== exp) begin fails++; $display("FAIL wrap_data%0d got %0d want %0d", k, out_data16, exp); end
            @(negedge clk);
        end
        tests++; if (acc16 !== 16'd64514) begin fails++; $display("FAIL wrap_acc16 got %0d want 64514", acc16); end
        tests++; if (acc !== 24'd130050) begin fails++; $display("FAIL wrap_acc24 got %0d want 130050", acc); end
        do_accept(8'd255, 8'd255, 1'b1);
        repeat (9) @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL clradd_valid got %0d want 1", out_valid); end
        tests++; if (acc16 !== 16'd65025 || acc !== 24'd65025) begin fails++; $display("FAIL clradd_acc got %0d/%0d want 65025", acc16, acc); end
        exp = q.pop_front();
        tests++; if (out_data !== exp) begin fails++; $display("FAIL clradd_data got %0d want %0d", out_data, exp); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n, r, sawv;
        logic [15:0] exp;
        stuck = 1'b1;
        do_accept(8'd3, 8'd4, 1'b0);
        n = 0; sawv = 0;
        while (!err && n < 40) begin
            if (out_valid) sawv++;
            @(negedge clk);
            n++;
        end
        tests++; if (n != 13) begin fails++; $display("FAIL to_err_cycle got %0d want 13", n); end
        tests++; if (sawv != 0 || out_valid !== 1'b0) begin fails++; $display("FAIL to_no_valid got %0d want 0", sawv); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL to_in_ready got %0d want 1", in_ready); end
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL to_sticky got %0d want 1", err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL to_clr got %0d want 0", err); end
        do_accept(8'd7, 8'd9, 1'b1);
        wait_valid(n, r);
        exp = q.pop_front();
        tests++; if (n != 10 || out_data !== exp) begin fails++; $display("FAIL to_next got %0d after %0d want %0d after 10", out_data, n, exp); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n, r;
        logic [15:0] exp;
        do_accept(8'd50, 8'd60, 1'b1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || mult_start !== 1'b0) begin fails++; $display("FAIL mid_ctrl got r=%0d v=%0d s=%0d want 1 0 0", in_ready, out_valid, mult_start); end
        tests++; if (out_data !== 16'd0 || acc !== 24'd0 || err !== 1'b0) begin fails++; $display("FAIL mid_data got d=%0d acc=%0d err=%0d want 0", out_data, acc, err); end
        tests++; if ({mult_a, mult_b} !== 16'd0) begin fails++; $display("FAIL mid_mult_ab got %0h want 0", {mult_a, mult_b}); end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_accept(8'd100, 8'd200, 1'b1);
        wait_valid(n, r);
        exp = q.pop_front();
        tests++; if (n != 10 || out_data !== exp) begin fails++; $display("FAIL mid_next got %0d after %0d want %0d after 10", out_data, n, exp); end
        tests++; if (acc !== 24'd20000) begin fails++; $display("FAIL mid_acc got %0d want 20000", acc); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached 200000 time units");
        $fatal(1, "bench timeout");
    end

endmodule
